// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that shares one up/down interval counter
// among NREQ requesters.
//
// A requester holds req[i] high and presents dir[i] and len[i]. The block grants the
// counter to one requester at a time and runs the count. It shows terminal count on
// ripple_out, then pulses done[i] to the winner for one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   clear_n    in   asynchronous active-low reset
//   req        in   [NREQ]     level requests; held for the whole interval
//   dir        in   [NREQ]     0 = count up 0..len, 1 = count down len..0
//   len        in   [NREQ*CW]  interval length; requester i uses [i*CW +: CW]
//   gnt        out  [NREQ]     registered one-hot grant
//   busy       out             counter owned (RUN)
//   count      out  [CW]       current counter value
//   ripple_out out             RUN and count at terminal (combinational)
//   done       out  [NREQ]     one-cycle completion pulse to the winner
module counter_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 6,
  parameter int unsigned MAXC = 20
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    dir,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic               ripple_out,
  output logic [NREQ-1:0]    done
);

  localparam int unsigned   IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] MaxVal  = CW'(MAXC);
  localparam logic [CW-1:0] One     = CW'(1);
  localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;     // last winner; search starts one past it
  logic [IW-1:0]   win_q, win_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   lenc_q, lenc_d;   // clamped length captured at grant
  logic [CW-1:0]   count_q, count_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic [CW-1:0]   len_a [NREQ];
  logic [CW-1:0]   term;
  logic [CW-1:0]   sel_len;
  logic            found;
  logic [IW-1:0]   pick;
  int unsigned     idx;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      len_a[i] = len[i*CW +: CW];
    end
  end

  // Round-robin search: first set request at ptr+1, ptr+2, ... (mod NREQ).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign term = dir_q ? '0 : lenc_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    dir_d   = dir_q;
    lenc_d  = lenc_q;
    count_d = count_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    sel_len = (len_a[pick] > MaxVal) ? MaxVal : len_a[pick];
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StRun;
          win_d   = pick;
          dir_d   = dir[pick];
          lenc_d  = sel_len;
          count_d = dir[pick] ? sel_len : '0;
          gnt_d   = OneHot0 << pick;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        // A dropped request aborts, ahead of both terminal detection and stepping.
        if (!req[win_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          count_d = '0;
          busy_d  = 1'b0;
          ptr_d   = win_q;
        end else if (count_q == term) begin
          state_d = StDone;
          gnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = OneHot0 << win_q;
          ptr_d   = win_q;
        end else begin
          count_d = dir_q ? (count_q - One) : (count_q + One);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      ptr_q   <= LastIdx;
      win_q   <= '0;
      dir_q   <= 1'b0;
      lenc_q  <= '0;
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      lenc_q  <= lenc_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign count      = count_q;
  assign ripple_out = (state_q == StRun) && (count_q == term);

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched.
//
// The driver issues request rounds. For each round, a model derives the grant order
// from the round-robin rule and queues one expected transaction per requester. A
// separate monitor pops an entry at each grant. It then checks the whole interval
// against count = k (up) or lenc-k (down), ripple at k == lenc, and done one cycle
// later. Abort and asynchronous reset are exercised directly.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int CW   = 6;
  localparam int MAXC = 20;

  logic               clk = 1'b0;
  logic               clear_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    dir;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [CW-1:0]      count;
  logic               ripple_out;
  logic [NREQ-1:0]    done;

  counter_sched #(
    .NREQ (NREQ),
    .CW   (CW),
    .MAXC (MAXC)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .req        (req),
    .dir        (dir),
    .len        (len),
    .gnt        (gnt),
    .busy       (busy),
    .count      (count),
    .ripple_out (ripple_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit d;
    int lenc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   mptr   = NREQ - 1;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expected transaction per grant, checked cycle by cycle.
  initial begin
    exp_t cur;
    bit   active;
    int   k;
    active = 1'b0;
    k      = 0;
    cur    = '{id: 0, d: 1'b0, lenc: 0};
    forever begin
      @(negedge clk);
      if (!mon_en || !clear_n) begin
        active = 1'b0;
      end else begin
        if (!active && gnt != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", int'(gnt), 0);
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            k      = 0;
            check("gnt_winner", int'(gnt), 1 << cur.id);
          end
        end
        if (active) begin
          if (k <= cur.lenc) begin
            check("count", int'(count), cur.d ? cur.lenc - k : k);
            check("ripple", int'(ripple_out), (k == cur.lenc) ? 1 : 0);
            check("busy_run", int'(busy), 1);
            check("gnt_hold", int'(gnt), 1 << cur.id);
            check("done_run", int'(done), 0);
          end else begin
            check("done_pulse", int'(done), 1 << cur.id);
            check("gnt_in_done", int'(gnt), 0);
            check("busy_in_done", int'(busy), 0);
            active = 1'b0;
          end
          k++;
        end else begin
          check("idle_done", int'(done), 0);
          check("idle_busy", int'(busy), 0);
        end
      end
    end
  end

  // Issue one round: every requester in mask is served once, in round-robin order.
  task automatic issue(input logic [NREQ-1:0] mask, input logic [NREQ*CW-1:0] lens,
                       input logic [NREQ-1:0] dirs, input bit scr);
    int   cyc;
    int   last;
    int   lv;
    exp_t e;
    len  = lens;
    dir  = dirs;
    last = mptr;
    for (int k = 1; k <= NREQ; k++) begin
      int id;
      id = (mptr + k) % NREQ;
      if (mask[id]) begin
        lv     = int'(lens[id*CW +: CW]);
        e.id   = id;
        e.d    = dirs[id];
        e.lenc = (lv > MAXC) ? MAXC : lv;
        exp_q.push_back(e);
        last = id;
      end
    end
    mptr = last;
    req  = mask;
    cyc  = 0;
    while (req != '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (gnt[i] && scr) begin
          // Captured values must not follow later input changes.
          len[i*CW +: CW] = CW'($urandom);
          dir[i]          = 1'($urandom);
        end
      end
    end
    check("round_timeout", int'(req), 0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    req     = '0;
    exp_q.delete();
    mptr    = NREQ - 1;
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] g, input int maxc);
    int c;
    c = 0;
    while (gnt != g && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("wait_gnt", int'(gnt), int'(g));
  endtask

  task automatic wait_count(input int v, input int maxc);
    int c;
    c = 0;
    while (int'(count) != v && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("wait_count", int'(count), v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_ripple"}, int'(ripple_out), 0);
  endtask

  initial begin
    logic [NREQ*CW-1:0] lens;
    logic [NREQ-1:0]    dirs;
    logic [NREQ-1:0]    mask;
    clear_n = 1'b0;
    req     = '0;
    dir     = '0;
    len     = '0;

    // Reset held with random requests: nothing may move.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req = NREQ'($urandom);
      dir = NREQ'($urandom);
      len = (NREQ*CW)'({$urandom, $urandom});
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    req     = '0;
    clear_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("rst_idle");
    end

    mon_en = 1'b1;
    // Single up interval: requester 1, len 5.
    lens = '0; lens[1*CW +: CW] = CW'(5);
    issue(4'b0010, lens, 4'b0000, 1'b1);
    // Down interval, len 3.
    lens = '0; lens[0 +: CW] = CW'(3);
    issue(4'b0001, lens, 4'b0001, 1'b1);
    // Down with clamp: 30 loads as 20.
    lens = '0; lens[0 +: CW] = CW'(30);
    issue(4'b0001, lens, 4'b0001, 1'b0);
    // Zero length, both directions.
    lens = '0;
    issue(4'b0001, lens, 4'b0000, 1'b0);
    issue(4'b0100, lens, 4'b0100, 1'b0);
    // Full contention, twice, len 2 each.
    for (int i = 0; i < NREQ; i++) lens[i*CW +: CW] = CW'(2);
    issue(4'b1111, lens, 4'b0000, 1'b0);
    issue(4'b1111, lens, 4'b1010, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      dirs = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) lens[i*CW +: CW] = CW'($urandom_range(0, 40));
      issue(mask, lens, dirs, 1'b1);
    end
    mon_en = 1'b0;

    // Abort: winner 2 drops at count 1. The pointer moves to 2, so 3 beats 0.
    do_reset();
    len = '0; len[2*CW +: CW] = CW'(5);
    dir = '0;
    req = 4'b0100;
    wait_gnt(4'b0100, 10);
    req = 4'b1101;
    wait_count(1, 10);
    req[2] = 1'b0;
    @(negedge clk);
    check("abort_gnt", int'(gnt), 0);
    check("abort_count", int'(count), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    check("after_abort_gnt", int'(gnt), 4'b1000);
    check("after_abort_done", int'(done), 0);

    // Asynchronous reset mid-RUN. Requester 0 is served first, moving the pointer
    // to 0; after reset the pointer must be back at NREQ-1.
    do_reset();
    mon_en = 1'b1;
    lens = '0; lens[0 +: CW] = CW'(2);
    issue(4'b0001, lens, 4'b0000, 1'b0);
    mon_en = 1'b0;
    len = '0; len[1*CW +: CW] = CW'(10);
    dir = '0;
    req = 4'b0010;
    wait_gnt(4'b0010, 10);
    wait_count(4, 10);
    #2;
    clear_n = 1'b0;
    req     = 4'b1011;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check("post_rst_winner", int'(gnt), 4'b0001);
    check("post_rst_done", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one mod-(MAXC+1) up/down interval counter between NREQ requesters. A requester asks for a timed interval of `len` ticks in a chosen direction. The block grants the counter to one requester at a time, runs the count and signals terminal count, then pulses `done` back to the winner. It sits between the requesting control blocks and the counter datapath, and replaces per-block private counters.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CW`, 6, counter and length width
- `MAXC`, 20, maximum terminal value; longer lengths are clamped to it
- `clk`  in  1  clock, rising edge
- `clear_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  level request; bit i held high for the whole interval
- `dir`  in  NREQ  direction for requester i: 0 = up from 0 to len, 1 = down from len to 0
- `len`  in  NREQ*CW  interval length; requester i uses bits [i*CW +: CW]
- `gnt`  out  NREQ  one-hot grant; registered
- `busy`  out  1  high while the counter is owned (RUN)
- `count`  out  CW  current counter value
- `ripple_out`  out  1  high while in RUN with count == terminal
- `done`  out  NREQ  one-hot, one-cycle completion pulse to the winner

## Operation
- States: IDLE, RUN, DONE.
- Reset state, asserted asynchronously while `clear_n`=0:
  - state IDLE; `gnt`, `done`, `busy`, `ripple_out` = 0; `count` = 0
  - last-winner pointer = NREQ-1, so requester 0 has first priority
- IDLE:
  - If any `req` bit is high, choose the first requester in round-robin order, starting at pointer+1 mod NREQ.
  - At that edge: set `gnt`; capture `dir` and the clamped `len` (min(len, MAXC)) into internal registers; load `count` = 0 for up or `count` = len_c for down; go to RUN.
- RUN:
  - Terminal value is len_c for up and 0 for down.
  - If `count` == terminal: go to DONE, `count` holds.
  - Otherwise step `count` by +1 (up) or -1 (down).
  - Abort: if the winner's `req` bit is 0 at an edge, that takes priority over stepping and terminal. Go to IDLE, clear `gnt`, `count` = 0, no `done`, and the pointer advances to the winner.
- DONE:
  - `done[winner]` = 1 for exactly this cycle; `gnt` = 0.
  - Pointer = winner.
  - Next edge always goes to IDLE.
- `len`/`dir` changes after the grant edge are ignored; only the captured values are used.
- Requests from non-winners are held off and never lost, as long as they stay high.
- `len` = 0 (either direction): `count` is 0 at grant, so terminal is hit in the first RUN cycle.
- Arithmetic is unsigned CW-bit. `count` never leaves 0..MAXC, so no wrap.

## Timing
- Grant latency: `req` seen high at edge t in IDLE → `gnt`/`busy` high after edge t.
- Interval: after the grant edge, count takes L further edges to reach terminal. `ripple_out` is high for the one RUN cycle at terminal. `done` is high in the cycle after that, i.e. L+1 edges after the grant edge.
- After `done`: one IDLE cycle, then the next grant at the following edge. Minimum grant-to-grant spacing is L+3 cycles.
- `ripple_out` is combinational from state/count/terminal registers; all other outputs are registered.
- Async reset mid-RUN: all outputs go to reset values immediately with no `done`. The pointer returns to NREQ-1.

## Test plan
- Reset and idle:
  - Stimulus: hold `clear_n`=0, drive random `req`, then release `clear_n` with `req`=0.
  - Required: all outputs 0 throughout; state stays IDLE.
- Single up interval:
  - Stimulus: `req[1]`=1, `dir[1]`=0, `len[1]`=5.
  - Required: `gnt`=0010; `count` runs 0,1,2,3,4,5; `ripple_out` high at 5; `done`=0010 one cycle later, 6 edges after grant; `gnt` low during `done`.
- Down interval and clamp:
  - Stimulus 1: `req[0]`, `dir`=1, `len`=3.
  - Required: `count` runs 3,2,1,0, then `done[0]`.
  - Stimulus 2: `len`=30.
  - Required: `count` loads 20 and counts down to 0.
  - Stimulus 3: `len`=0.
  - Required: `ripple_out` high in the first RUN cycle; `done` on the next cycle.
- Round-robin contention:
  - Stimulus: `req`=1111 held, each with `len`=2.
  - Required: grants go in order 0,1,2,3,0; no requester is granted twice before the others have been served.
- Abort:
  - Stimulus: winner 2 drops `req` while `count`=1, up direction.
  - Required: next edge gives `gnt`=0, `count`=0, no `done`; the pending `req[3]` is granted next.
- Reset mid-operation:
  - Stimulus: assert `clear_n`=0 asynchronously while `count`=4 in RUN.
  - Required: outputs clear without waiting for a clock edge; after release, requester 0 wins if several requests are pending.
